// File: rtl/key_responder.sv
// ----------------------------------------------------------------------------
// key_responder
//
// Responding end of the key_req / key_id / key_ack / key interface. Holds
// NUM_KEYS slots. Each slot has a 32-bit ID, a valid bit and eight 32-bit key
// words. A request walks the slots one per cycle, and the lowest matching
// index wins. On a hit, the key is gathered one word per cycle, MSB word
// first. The result is returned with a single-cycle key_ack.
//
// Ports
//   clk156         sole clock
//   areset_clk156  asynchronous, active-high reset
//   key_req        request strobe (sampled only while idle)
//   key_id         requested key ID, sampled with key_req
//   key_ack        one-cycle response strobe
//   key_valid      1 = hit, 0 = miss; valid from key_ack onwards
//   key            returned key, held until the next key_ack
//   busy           high whenever a request is in progress
//   cfg_we         config write strobe
//   cfg_addr       {slot, word[3:0]}:
//                    word 0     = ID
//                    word 1     = bit 0 is the valid bit
//                    words 8-15 = key words 0-7
//   cfg_wdata      config write data
//   hit_count      saturating hit counter
//   miss_count     saturating miss counter
// ----------------------------------------------------------------------------
module key_responder #(
  parameter  int NUM_KEYS      = 4,
  localparam int SLOT_BITS     = $clog2(NUM_KEYS),
  localparam int CFG_ADDR_BITS = SLOT_BITS + 4
) (
  input  logic                     clk156,
  input  logic                     areset_clk156,
  input  logic                     key_req,
  input  logic [31:0]              key_id,
  output logic                     key_ack,
  output logic                     key_valid,
  output logic [255:0]             key,
  output logic                     busy,
  input  logic                     cfg_we,
  input  logic [CFG_ADDR_BITS-1:0] cfg_addr,
  input  logic [31:0]              cfg_wdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_FETCH,
    S_ACK
  } state_t;

  // Slot storage
  logic [31:0]         r_slot_id    [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_slot_valid;
  logic [31:0]         r_slot_word  [NUM_KEYS][8];

  // Request engine
  state_t               r_state;
  logic [31:0]          r_id_reg;
  logic [SLOT_BITS-1:0] r_idx;
  logic [SLOT_BITS-1:0] r_slot;
  logic [2:0]           r_w;
  logic [255:0]         r_key_shift;

  // Registered outputs
  logic                 r_key_ack;
  logic                 r_key_valid;
  logic [255:0]         r_key;
  logic                 r_busy;
  logic [31:0]          r_hit_count;
  logic [31:0]          r_miss_count;

  logic [SLOT_BITS-1:0] w_cfg_slot;
  logic [3:0]           w_cfg_word;
  logic                 w_cfg_slot_ok;
  logic                 w_slot_match;
  logic                 w_last_idx;
  logic [31:0]          w_fetch_word;
  logic [255:0]         w_shift_next;

  assign w_cfg_slot    = cfg_addr[CFG_ADDR_BITS-1:4];
  assign w_cfg_word    = cfg_addr[3:0];
  // With a non-power-of-two NUM_KEYS, addresses beyond the last slot are dropped.
  assign w_cfg_slot_ok = (32'(w_cfg_slot) < NUM_KEYS);

  // The valid bit and ID are read live, so a valid bit cleared mid-search
  // turns that slot into a miss.
  assign w_slot_match  = r_slot_valid[r_idx] && (r_slot_id[r_idx] == r_id_reg);
  assign w_last_idx    = (r_idx == SLOT_BITS'(NUM_KEYS - 1));
  assign w_fetch_word  = r_slot_word[r_slot][r_w];
  assign w_shift_next  = {r_key_shift[223:0], w_fetch_word};

  // --------------------------------------------------------------------------
  // Config write port. Writes are accepted in every engine state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      // NOTE: slot storage is cleared by reset so that every slot reads as
      // invalid afterwards. That is why these are flops and not a RAM macro.
      for (int s = 0; s < NUM_KEYS; s++) begin
        r_slot_id[s] <= '0;
        for (int w = 0; w < 8; w++) begin
          r_slot_word[s][w] <= '0;
        end
      end
      r_slot_valid <= '0;
    end else if (cfg_we && w_cfg_slot_ok) begin
      if (w_cfg_word == 4'd0) begin
        r_slot_id[w_cfg_slot] <= cfg_wdata;
      end else if (w_cfg_word == 4'd1) begin
        r_slot_valid[w_cfg_slot] <= cfg_wdata[0];
      end else if (w_cfg_word[3]) begin
        r_slot_word[w_cfg_slot][w_cfg_word[2:0]] <= cfg_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request engine. The outputs are registered. key_ack, key, key_valid and
  // the counters are loaded on the edge that enters S_ACK, so they are
  // visible for the whole ACK cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      r_state      <= S_IDLE;
      r_id_reg     <= '0;
      r_idx        <= '0;
      r_slot       <= '0;
      r_w          <= '0;
      r_key_shift  <= '0;
      r_key_ack    <= 1'b0;
      r_key_valid  <= 1'b0;
      r_key        <= '0;
      r_busy       <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      // NOTE: non-blocking assignments let every branch below read the
      // pre-edge value of each register, regardless of statement order.
      r_key_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_req) begin
            r_id_reg <= key_id;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SEARCH;
          end
        end

        S_SEARCH: begin
          if (w_slot_match) begin
            r_slot  <= r_idx;
            r_w     <= '0;
            r_state <= S_FETCH;
          end else if (w_last_idx) begin
            r_key_ack   <= 1'b1;
            r_key_valid <= 1'b0;
            r_key       <= '0;
            if (r_miss_count != '1) begin
              r_miss_count <= r_miss_count + 32'd1;
            end
            r_state <= S_ACK;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_FETCH: begin
          r_key_shift <= w_shift_next;
          r_w         <= r_w + 3'd1;
          if (r_w == 3'd7) begin
            r_key_ack   <= 1'b1;
            r_key_valid <= 1'b1;
            r_key       <= w_shift_next;
            if (r_hit_count != '1) begin
              r_hit_count <= r_hit_count + 32'd1;
            end
            r_state <= S_ACK;
          end
        end

        S_ACK: begin
          // key_req is deliberately ignored here. The next request is taken
          // from IDLE on the following cycle.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign key_ack    = r_key_ack;
  assign key_valid  = r_key_valid;
  assign key        = r_key;
  assign busy       = r_busy;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_key_responder.sv
// ----------------------------------------------------------------------------
// tb_key_responder
//
// Bench for key_responder, built around a behavioural model. The model keeps
// the slot contents. At the moment a request is accepted, it resolves the
// answer from the slot rules: the lowest valid match wins, and the key words
// are laid out MSB first. The acknowledge cycle follows from the latency
// formula. A negedge compare process checks every DUT output against the
// model on every cycle. Directed sections add hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_key_responder;

  localparam int NUM_KEYS      = 4;
  localparam int CFG_ADDR_BITS = $clog2(NUM_KEYS) + 4;

  logic                     clk156;
  logic                     areset_clk156;
  logic                     key_req;
  logic [31:0]              key_id;
  logic                     key_ack;
  logic                     key_valid;
  logic [255:0]             key;
  logic                     busy;
  logic                     cfg_we;
  logic [CFG_ADDR_BITS-1:0] cfg_addr;
  logic [31:0]              cfg_wdata;
  logic [31:0]              hit_count;
  logic [31:0]              miss_count;

  key_responder #(.NUM_KEYS(NUM_KEYS)) dut (
    .clk156        (clk156),
    .areset_clk156 (areset_clk156),
    .key_req       (key_req),
    .key_id        (key_id),
    .key_ack       (key_ack),
    .key_valid     (key_valid),
    .key           (key),
    .busy          (busy),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [31:0]  m_id    [NUM_KEYS];
  bit           m_valid [NUM_KEYS];
  logic [31:0]  m_word  [NUM_KEYS][8];
  int           m_cur      = 0;     // index of the current cycle
  bit           m_inflight = 1'b0;
  int           m_ack_cyc  = 0;     // cycle in which key_ack is due
  bit           m_pend_hit;
  logic [255:0] m_pend_key;
  bit           e_ack, e_valid, e_busy;
  logic [255:0] e_key;
  logic [31:0]  m_hits, m_miss;

  function automatic bit m_idle();
    return !m_inflight || (m_cur > m_ack_cyc);
  endfunction

  always @(posedge clk156 or posedge areset_clk156) begin
    if (areset_clk156) begin
      for (int s = 0; s < NUM_KEYS; s++) begin
        m_id[s] = '0;
        m_valid[s] = 1'b0;
        for (int w = 0; w < 8; w++) m_word[s][w] = '0;
      end
      m_inflight = 1'b0;
      e_ack = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_key = '0;
      m_hits = '0; m_miss = '0;
    end else begin
      int  k;
      int  ws, ww, s_hit;
      bit  hit;
      k = m_cur;
      // Outputs for cycle k+1 that follow from a request already in flight.
      e_ack = 1'b0;
      if (m_inflight && (k + 1 == m_ack_cyc)) begin
        e_ack   = 1'b1;
        e_valid = m_pend_hit;
        e_key   = m_pend_hit ? m_pend_key : '0;
        if (m_pend_hit) begin
          if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
        end else begin
          if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
        end
      end
      // A config write lands on this edge, ahead of any slot lookup.
      if (cfg_we) begin
        ws = int'(cfg_addr[CFG_ADDR_BITS-1:4]);
        ww = int'(cfg_addr[3:0]);
        if (ww == 0)      m_id[ws]        = cfg_wdata;
        else if (ww == 1) m_valid[ws]     = cfg_wdata[0];
        else if (ww >= 8) m_word[ws][ww-8] = cfg_wdata;
      end
      // A new request is accepted only while idle.
      if (m_idle() && key_req) begin
        hit = 1'b0;
        s_hit = 0;
        for (int s = 0; s < NUM_KEYS; s++) begin
          if (!hit && m_valid[s] && (m_id[s] == key_id)) begin
            hit = 1'b1;
            s_hit = s;
          end
        end
        m_pend_hit = hit;
        m_pend_key = '0;
        if (hit) begin
          for (int w = 0; w < 8; w++) m_pend_key[255-32*w -: 32] = m_word[s_hit][w];
        end
        m_inflight = 1'b1;
        m_ack_cyc  = k + (hit ? 10 + s_hit : NUM_KEYS + 1);
      end
      e_busy = m_inflight && (k + 1 <= m_ack_cyc);
      m_cur  = m_cur + 1;
    end
  end

  // Compare process: every output on every cycle, sampled mid-period.
  always @(negedge clk156) begin
    if (chk_en) begin
      check("ack",        256'(key_ack),    256'(e_ack));
      check("key_valid",  256'(key_valid),  256'(e_valid));
      check("key",        key,              e_key);
      check("busy",       256'(busy),       256'(e_busy));
      check("hit_count",  256'(hit_count),  256'(m_hits));
      check("miss_count", 256'(miss_count), 256'(m_miss));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Each is entered and left 2 time units after a posedge.
  // --------------------------------------------------------------------------
  task automatic cfg_write(input int slot, input int word, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = CFG_ADDR_BITS'(slot * 16 + word);
    cfg_wdata = d;
    @(posedge clk156); #2;
    cfg_we = 1'b0;
  endtask

  task automatic load_slot(input int slot, input logic [31:0] id, input logic [31:0] base);
    cfg_write(slot, 0, id);
    for (int w = 0; w < 8; w++) cfg_write(slot, 8 + w, base + 32'(w));
    cfg_write(slot, 1, 32'h1);
  endtask

  // Issues a request (cycle 0 = the current cycle). Returns the cycle in which
  // key_ack was seen (-1 on timeout). Also reports whether busy was low in
  // cycle 0 and high on every later cycle up to the ack. With intr set, a
  // second request for intr_id is pulsed in cycle 3, while the DUT is busy.
  task automatic do_req(input logic [31:0] id, input bit intr, input logic [31:0] intr_id,
                        output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    key_req = 1'b1;
    key_id  = id;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk156);
      if (n == 0 && busy) busy_ok = 1'b0;
      if (n > 0 && !busy) busy_ok = 1'b0;
      if (key_ack) begin
        lat = n;
        break;
      end
      @(posedge clk156); #2;
      key_req = intr && (n == 2);
      key_id  = (intr && n == 2) ? intr_id : id;
    end
    @(posedge clk156); #2;
    key_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && !m_idle(); n++) begin
      @(posedge clk156); #2;
    end
    check("wait_idle", 256'(m_idle()), 256'(1));
  endtask

  localparam logic [255:0] KEY_SLOT2 =
    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [255:0] KEY_SLOT1 =
    256'hA0000000_A0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007;

  initial begin
    int lat;
    int acks;
    bit bok;
    int r;
    logic [31:0] ids [4];

    areset_clk156 = 1'b1;
    key_req = 1'b0; key_id = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk156);
    #2 areset_clk156 = 1'b0;
    @(negedge clk156);
    check("rst_busy",  256'(busy),       256'(0));
    check("rst_ack",   256'(key_ack),    256'(0));
    check("rst_key",   key,              256'(0));
    check("rst_hits",  256'(hit_count),  256'(0));
    check("rst_miss",  256'(miss_count), 256'(0));
    @(posedge clk156); #2;
    chk_en = 1'b1;

    // 1. Empty table: miss after NUM_KEYS+1 = 5 cycles.
    do_req(32'h1, 1'b0, '0, lat, bok);
    check("t1_lat",   256'(lat),        256'(5));
    check("t1_busy",  256'(bok),        256'(1));
    check("t1_valid", 256'(key_valid),  256'(0));
    check("t1_key",   key,              256'(0));
    check("t1_miss",  256'(miss_count), 256'(1));

    // 2. Hit on slot 2: ack in cycle 12.
    for (int w = 0; w < 8; w++) cfg_write(2, 8 + w, 32'h1111_1111 * 32'(w + 1));
    cfg_write(2, 0, 32'hDEAD_BEEF);
    cfg_write(2, 1, 32'h1);
    do_req(32'hDEAD_BEEF, 1'b0, '0, lat, bok);
    check("t2_lat",   256'(lat),       256'(12));
    check("t2_key",   key,             KEY_SLOT2);
    check("t2_valid", 256'(key_valid), 256'(1));
    check("t2_hits",  256'(hit_count), 256'(1));

    // 3. Duplicate IDs in slots 1 and 3: the lower slot wins, ack in cycle 11.
    load_slot(1, 32'h5, 32'hA000_0000);
    load_slot(3, 32'h5, 32'hB000_0000);
    do_req(32'h5, 1'b0, '0, lat, bok);
    check("t3_lat", 256'(lat), 256'(11));
    check("t3_key", key,       KEY_SLOT1);

    // 4. A second request while busy is ignored.
    do_req(32'h5, 1'b1, 32'hDEAD_BEEF, lat, bok);
    check("t4_lat", 256'(lat), 256'(11));
    check("t4_key", key,       KEY_SLOT1);
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk156);
      if (key_ack) acks++;
      @(posedge clk156); #2;
    end
    check("t4_no_2nd_ack", 256'(acks), 256'(0));

    // 6b. Clearing valid before the request turns a hit into a miss.
    cfg_write(2, 1, 32'h0);
    do_req(32'hDEAD_BEEF, 1'b0, '0, lat, bok);
    check("t6_clr_lat",   256'(lat),       256'(5));
    check("t6_clr_valid", 256'(key_valid), 256'(0));
    cfg_write(1, 1, 32'hFFFF_FFFE);   // bit 0 clear: slot 3 now serves ID 5
    do_req(32'h5, 1'b0, '0, lat, bok);
    check("t6_slot3_lat", 256'(lat), 256'(13));

    // Randomized traffic. Config writes are issued only while idle.
    ids[0] = 32'h5; ids[1] = 32'hDEAD_BEEF; ids[2] = 32'h77; ids[3] = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      cfg_we  = 1'b0;
      key_req = 1'b0;
      r = int'($urandom_range(0, 9));
      if (r < 4 && m_idle()) begin
        int wsel;
        logic [31:0] d;
        wsel = int'($urandom_range(0, 15));
        d = $urandom;
        if (wsel == 0) d = ids[$urandom_range(0, 3)];
        cfg_we    = 1'b1;
        cfg_addr  = CFG_ADDR_BITS'($urandom_range(0, NUM_KEYS - 1) * 16 + wsel);
        cfg_wdata = d;
      end else if (r < 7) begin
        key_req = 1'b1;
        key_id  = ($urandom_range(0, 7) == 0) ? $urandom : ids[$urandom_range(0, 3)];
      end
      @(posedge clk156); #2;
    end
    cfg_we = 1'b0;
    key_req = 1'b0;
    wait_idle();

    // 6a. Miss counter saturation.
    force dut.r_miss_count = 32'hFFFF_FFFE;
    m_miss = 32'hFFFF_FFFE;
    #1 release dut.r_miss_count;
    @(posedge clk156); #2;
    do_req(32'h1234_5678, 1'b0, '0, lat, bok);
    check("t6_sat1", 256'(miss_count), 256'(32'hFFFF_FFFF));
    do_req(32'h1234_5678, 1'b0, '0, lat, bok);
    check("t6_sat2", 256'(miss_count), 256'(32'hFFFF_FFFF));

    // 5. Reset during the 4th FETCH cycle of a slot-0 hit: no ack, all cleared.
    load_slot(0, 32'h77, 32'hC000_0000);
    key_req = 1'b1;
    key_id  = 32'h77;
    acks = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk156);
      if (key_ack) acks++;
      @(posedge clk156); #2;
      key_req = 1'b0;
      if (n == 4) areset_clk156 = 1'b1;   // now in cycle 5 = 4th FETCH cycle
      if (n == 7) areset_clk156 = 1'b0;
    end
    check("t5_no_ack", 256'(acks),       256'(0));
    check("t5_busy",   256'(busy),       256'(0));
    check("t5_key",    key,              256'(0));
    check("t5_valid",  256'(key_valid),  256'(0));
    check("t5_hits",   256'(hit_count),  256'(0));
    check("t5_miss",   256'(miss_count), 256'(0));
    do_req(32'h77, 1'b0, '0, lat, bok);
    check("t5_rep_lat",  256'(lat),        256'(5));
    check("t5_rep_miss", 256'(miss_count), 256'(1));

    repeat (2) @(posedge clk156);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
